// File: rtl/imem_sync_if.sv
//==============================================================================
// Module      : imem_sync_if
// Description : Bus bundle for the synchronous instruction memory. It carries
//               the program-load port, the fetch request/response handshake
//               and the status outputs.
//               master : host / fetch stage (drives load_* and fetch_*)
//               slave  : imem_sync (drives fetch_ready, inst_*, fault, busy)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface imem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              load_mode;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] inst_addr;
    logic              fault;
    logic              busy;

    modport master (
        output load_mode, load_we, load_addr, load_data,
        output fetch_req, fetch_addr, fetch_stall,
        input  fetch_ready, inst_valid, instruction, inst_addr, fault, busy
    );

    modport slave (
        input  load_mode, load_we, load_addr, load_data,
        input  fetch_req, fetch_addr, fetch_stall,
        output fetch_ready, inst_valid, instruction, inst_addr, fault, busy
    );
endinterface

`default_nettype wire

// File: rtl/imem_sync.sv
//==============================================================================
// Module      : imem_sync
// Description : Parametrised synchronous instruction memory. After reset the
//               array is cleared to NOP_WORD (one word per cycle), then the
//               fetch stage reads it with one-cycle latency through a
//               valid/ready handshake that holds its output while stalled.
//               A host can enter LOAD mode to write the program.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high
//               bus   - imem_sync_if.slave (load port, fetch port, status)
// Options     : IMEM_RANGE_CHECK_EN - when defined, out-of-range or
//               misaligned addresses fault on fetch and are dropped on load;
//               otherwise addresses wrap modulo DEPTH and fault stays 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_sync #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 16,
    parameter int                 ADDR_W    = 32,
    parameter int                 BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD  = '0
) (
    input  wire          clk,
    input  wire          reset,
    imem_sync_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    // Byte addresses drop the two alignment bits before indexing.
    localparam int SHIFT = (BYTE_ADDR != 0) ? 2 : 0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_load_idx;
    logic              w_fetch_illegal;
    logic              w_load_illegal;
    logic              w_fetch_ready;
    logic              w_accept;

    assign w_fetch_idx = IDX_W'(bus.fetch_addr >> SHIFT);
    assign w_load_idx  = IDX_W'(bus.load_addr >> SHIFT);

`ifdef IMEM_RANGE_CHECK_EN
    function automatic logic f_illegal(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] upper;
        upper = a >> (IDX_W + SHIFT);
        return (upper != '0) || ((BYTE_ADDR != 0) && (a[1:0] != 2'b00));
    endfunction

    assign w_fetch_illegal = f_illegal(bus.fetch_addr);
    assign w_load_illegal  = f_illegal(bus.load_addr);
`else
    // Addresses wrap; the bits above the index field are deliberately dropped.
    logic w_unused_load_addr;
    assign w_unused_load_addr = ^bus.load_addr;
    assign w_fetch_illegal    = 1'b0;
    assign w_load_illegal     = 1'b0;
`endif

    // Ready drops combinationally as soon as load_mode rises so no fetch is
    // accepted on the cycle the host asks for the array.
    assign w_fetch_ready = (r_state == ST_RUN) && !bus.load_mode &&
                           (!r_valid || !bus.fetch_stall);
    assign w_accept      = bus.fetch_req && w_fetch_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_valid <= 1'b0;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_instr <= w_fetch_illegal ? NOP_WORD : r_mem[w_fetch_idx];
                        r_addr  <= bus.fetch_addr;
                        r_fault <= w_fetch_illegal;
                    end else if (!(r_valid && bus.fetch_stall)) begin
                        r_valid <= 1'b0;
                    end
                    // A stalled output must be drained before the array is
                    // handed to the loader.
                    if (bus.load_mode && (!r_valid || !bus.fetch_stall)) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_valid <= 1'b0;
                    if (!bus.load_mode) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // The array itself has no reset; CLEAR rewrites every word instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= NOP_WORD;
        end else if ((r_state == ST_LOAD) && bus.load_we && !w_load_illegal) begin
            r_mem[w_load_idx] <= bus.load_data;
        end
    end

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.inst_valid  = r_valid;
    assign bus.instruction = r_instr;
    assign bus.inst_addr   = r_addr;
    assign bus.fault       = r_fault;
    assign bus.busy        = (r_state != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_imem_sync.sv
//==============================================================================
// Module      : tb_imem_sync
// Description : Self-checking bench for imem_sync (DEPTH=16, BYTE_ADDR=1).
//               Directed scenarios followed by randomized traffic; a
//               behavioural model predicts every output each cycle.
//               Honours IMEM_RANGE_CHECK_EN the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_sync;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] NOP    = 32'h0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_sync #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BYTE_ADDR(1),
        .NOP_WORD (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = clearing, 1 = running, 2 = loading
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_mem [DEPTH];
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_addr  = 32'h0;
    logic        m_old_valid;

    function automatic bit illegal(input logic [31:0] a);
`ifdef IMEM_RANGE_CHECK_EN
        return (a >= 32'(DEPTH * 4)) || (a % 4 != 0);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_instr = 32'h0;
            m_addr  = 32'h0;
        end else begin
            m_old_valid = m_valid;
            if (m_phase == 0) begin
                m_mem[m_cnt] = NOP;
                m_cnt++;
                if (m_cnt == DEPTH) m_phase = 1;
                m_valid = 1'b0;
            end else if (m_phase == 1) begin
                if (bus.fetch_req && !bus.load_mode && (!m_valid || !bus.fetch_stall)) begin
                    m_valid = 1'b1;
                    m_addr  = bus.fetch_addr;
                    m_fault = illegal(bus.fetch_addr);
                    m_instr = m_fault ? NOP : m_mem[word_idx(bus.fetch_addr)];
                end else if (!(m_valid && bus.fetch_stall)) begin
                    m_valid = 1'b0;
                end
                if (bus.load_mode && (!m_old_valid || !bus.fetch_stall)) m_phase = 2;
            end else begin
                m_valid = 1'b0;
                if (bus.load_we && !illegal(bus.load_addr))
                    m_mem[word_idx(bus.load_addr)] = bus.load_data;
                if (!bus.load_mode) m_phase = 1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (reset || m_phase >= 0) begin
            check("busy",        32'(bus.busy),       32'(m_phase != 1));
            check("fetch_ready", 32'(bus.fetch_ready),
                  32'((m_phase == 1) && !bus.load_mode && (!m_valid || !bus.fetch_stall)));
            check("inst_valid",  32'(bus.inst_valid), 32'(m_valid));
            check("instruction", bus.instruction,     m_instr);
            check("inst_addr",   bus.inst_addr,       m_addr);
            if (m_valid || reset) check("fault", 32'(bus.fault), 32'(m_fault));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.load_mode   = 1'b0;
        bus.load_we     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_stall = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    task automatic wait_clear();
        repeat (15) tick();
        lit("clear_busy_15", 32'(bus.busy), 32'd1);
        lit("clear_ready_15", 32'(bus.fetch_ready), 32'd0);
        tick();
        lit("clear_busy_16", 32'(bus.busy), 32'd0);
        lit("clear_ready_16", 32'(bus.fetch_ready), 32'd1);
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        #1;
        lit("rst_valid", 32'(bus.inst_valid), 32'd0);
        lit("rst_instr", bus.instruction, 32'h0);
        lit("rst_busy",  32'(bus.busy), 32'd1);
        repeat (3) tick();
        reset = 1'b0;
        wait_clear();

        // first fetch after clear returns the cleared word
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
        tick();
        bus.fetch_req = 1'b0;
        lit("clr_fetch_valid", 32'(bus.inst_valid), 32'd1);
        lit("clr_fetch_instr", bus.instruction, 32'h0);
        lit("clr_fetch_addr",  bus.inst_addr, 32'h4);

        // program load
        bus.load_mode = 1'b1;
        tick();
        lit("load_busy", 32'(bus.busy), 32'd1);
        bus.load_we = 1'b1; bus.load_addr = 32'h0; bus.load_data = 32'h0001_1020;
        tick();
        bus.load_addr = 32'h4; bus.load_data = 32'h0001_1823;
        tick();
        bus.load_addr = 32'h8; bus.load_data = 32'h0001_1824;
        tick();
        bus.load_we = 1'b0; bus.load_mode = 1'b0;
        tick();

        // back-to-back fetches
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        tick();
        lit("b2b_0", bus.instruction, 32'h0001_1020);
        lit("b2b_0_addr", bus.inst_addr, 32'h0);
        bus.fetch_addr = 32'h4;
        tick();
        lit("b2b_1", bus.instruction, 32'h0001_1823);
        lit("b2b_1_addr", bus.inst_addr, 32'h4);
        bus.fetch_addr = 32'h8;
        tick();
        lit("b2b_2", bus.instruction, 32'h0001_1824);
        lit("b2b_2_valid", 32'(bus.inst_valid), 32'd1);
        bus.fetch_req = 1'b0;
        tick();
        lit("b2b_drop_valid", 32'(bus.inst_valid), 32'd0);

        // stall hold
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        tick();
        bus.fetch_stall = 1'b1; bus.fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("stall_hold", bus.instruction, 32'h0001_1020);
            lit("stall_ready", 32'(bus.fetch_ready), 32'd0);
        end
        bus.fetch_stall = 1'b0;
        tick();
        lit("stall_release", bus.instruction, 32'h0001_1823);
        lit("stall_release_addr", bus.inst_addr, 32'h4);
        bus.fetch_req = 1'b0;
        tick();

        // range handling
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40;
        tick();
`ifdef IMEM_RANGE_CHECK_EN
        lit("range_40_fault", 32'(bus.fault), 32'd1);
        lit("range_40_instr", bus.instruction, 32'h0);
        bus.fetch_addr = 32'h6;
        tick();
        lit("range_6_fault", 32'(bus.fault), 32'd1);
        bus.fetch_req = 1'b0; bus.load_mode = 1'b1;
        tick();
        bus.load_we = 1'b1; bus.load_addr = 32'h44; bus.load_data = 32'hDEAD_BEEF;
        tick();
        bus.load_we = 1'b0; bus.load_mode = 1'b0;
        tick();
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
        tick();
        lit("range_load_ignored", bus.instruction, 32'h0001_1823);
`else
        lit("wrap_40_instr", bus.instruction, 32'h0001_1020);
        lit("wrap_40_fault", 32'(bus.fault), 32'd0);
`endif
        bus.fetch_req = 1'b0;
        tick();

        // load entry while stalled
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        tick();
        bus.fetch_req = 1'b0; bus.fetch_stall = 1'b1; bus.load_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            lit("stalled_entry_busy", 32'(bus.busy), 32'd0);
            lit("stalled_entry_valid", 32'(bus.inst_valid), 32'd1);
        end
        bus.fetch_stall = 1'b0;
        tick();
        lit("entry_after_release_busy", 32'(bus.busy), 32'd1);
        lit("entry_after_release_valid", 32'(bus.inst_valid), 32'd0);

        // reset mid-load
        bus.load_we = 1'b1; bus.load_addr = 32'h0; bus.load_data = 32'h0001_1020;
        tick();
        bus.load_we = 1'b0;
        reset = 1'b1;
        #1;
        lit("midrst_valid", 32'(bus.inst_valid), 32'd0);
        lit("midrst_instr", bus.instruction, 32'h0);
        lit("midrst_addr",  bus.inst_addr, 32'h0);
        lit("midrst_ready", 32'(bus.fetch_ready), 32'd0);
        tick();
        reset = 1'b0; bus.load_mode = 1'b0;
        wait_clear();
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        tick();
        lit("midrst_refetch", bus.instruction, 32'h0);
        lit("midrst_refetch_valid", 32'(bus.inst_valid), 32'd1);
        bus.fetch_req = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) bus.load_mode = !bus.load_mode;
            bus.fetch_req   = ($urandom_range(0, 3) != 0);
            bus.fetch_stall = ($urandom_range(0, 3) == 0);
            bus.fetch_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                          : 32'($urandom_range(0, DEPTH - 1) * 4);
            bus.load_we     = ($urandom_range(0, 1) == 1);
            bus.load_addr   = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                          : 32'($urandom_range(0, DEPTH - 1) * 4);
            bus.load_data   = 32'($urandom);
            tick();
        end

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
